// File: rtl/alu_issue_seq.sv
// Instruction sequencer and 4-entry register file feeding a registered 8-bit ALU.
// Optional debug read port enabled by defining RF_DEBUG_EN.
module alu_issue_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_instr,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [7:0]            alu_instr,
  input  logic [DATA_WIDTH-1:0] alu_y,
  output logic                  wb_valid,
  output logic [1:0]            wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  busy
`ifdef RF_DEBUG_EN
  ,
  input  logic [1:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [7:0] OP_PASS_B = 8'h07;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_rf [4];
  logic [DATA_WIDTH-1:0] r_last_y;

  // Held fields of the accepted ALU instruction
  logic [1:0]            r_dst;
  logic [1:0]            r_srca;
  logic [1:0]            r_srcb;
  logic                  r_nowb;
  logic [7:0]            r_op;

  logic                  r_wb_valid;
  logic [1:0]            r_wb_addr;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_ldi;
  logic [1:0]            w_in_dst;
  logic [DATA_WIDTH-1:0] w_imm;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = in_valid && w_idle;
  assign w_ldi    = in_instr[9];
  assign w_in_dst = in_instr[15:14];
  assign w_imm    = DATA_WIDTH'(in_instr[7:0]);

  assign in_ready = w_idle;
  assign busy     = !w_idle;
  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;

  // Outside READ the ALU is fed pass-through-B of its own result so Y stays put.
  always_comb begin
    alu_a     = '0;
    alu_b     = r_last_y;
    alu_instr = OP_PASS_B;
    case (r_state)
      S_READ: begin
        alu_a     = r_rf[r_srca];
        alu_b     = r_rf[r_srcb];
        alu_instr = r_op;
      end
      S_WB: begin
        alu_b = alu_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      for (int unsigned i = 0; i < 4; i++) begin
        r_rf[i] <= '0;
      end
      r_last_y   <= '0;
      r_dst      <= '0;
      r_srca     <= '0;
      r_srcb     <= '0;
      r_nowb     <= 1'b0;
      r_op       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_ldi) begin
              r_rf[w_in_dst] <= w_imm;
              r_wb_valid     <= 1'b1;
              r_wb_addr      <= w_in_dst;
              r_wb_data      <= w_imm;
            end else begin
              r_dst   <= w_in_dst;
              r_srca  <= in_instr[13:12];
              r_srcb  <= in_instr[11:10];
              r_nowb  <= in_instr[8];
              r_op    <= in_instr[7:0];
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_state <= S_WB;
        end
        S_WB: begin
          r_last_y <= alu_y;
          if (!r_nowb) begin
            r_rf[r_dst] <= alu_y;
            r_wb_valid  <= 1'b1;
            r_wb_addr   <= r_dst;
            r_wb_data   <= alu_y;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RF_DEBUG_EN
  assign dbg_data = r_rf[dbg_addr];
`endif

endmodule
